// File: rtl/pixel_stream_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_stream_sequencer_pkg                                   |
// | Description : Shared types and constants for the pixel stream sequencer:   |
// |               RGB888 pixel type, sequencer state encoding, default error   |
// |               pixel and a saturating 8-bit increment helper.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pixel_stream_sequencer_pkg;

  // One packed 8:8:8 pixel, red in the top byte.
  typedef logic [23:0] rgb888_t;

  // Sequencer states, one pass through FETCH..GAP per pixel.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_GAP      = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  // Pure red marks a pixel the processor never returned.
  localparam rgb888_t C_ERR_PIXEL_DEFAULT = 24'hFF0000;

  // Event counters stick at 255 instead of wrapping back to a small number.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_stream_sequencer_cycle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_stream_sequencer_cycle_timer                           |
// | Description : Clearable up-counter with a registered terminal-count flag.  |
// |               Counts enabled cycles; reached goes high in the cycle after  |
// |               the count becomes TERMINAL and stays high until clear.       |
// | Ports       : clk, rst_n   - clock, asynchronous active-low reset          |
// |               clear        - synchronous restart (count 0)                 |
// |               enable       - count this cycle                              |
// |               reached      - count has reached TERMINAL (registered)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pixel_stream_sequencer_cycle_timer #(
  parameter int TERMINAL = 1000,
  parameter int CNT_W    = (TERMINAL < 1) ? 1 : $clog2(TERMINAL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic reached
);

  localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(TERMINAL);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             reached_q, reached_d;

  always_comb begin
    count_d   = count_q;
    reached_d = reached_q;
    if (clear) begin
      count_d   = '0;
      // A zero terminal count is satisfied immediately after a clear.
      reached_d = (C_TERMINAL == '0);
    end else if (enable && !reached_q) begin
      // Counting stops at the terminal value so the flag is sticky.
      count_d   = count_q + C_ONE;
      reached_d = (count_d == C_TERMINAL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      reached_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      reached_q <= reached_d;
    end
  end

  assign reached = reached_q;

endmodule
`default_nettype wire

// File: rtl/pixel_stream_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_stream_sequencer                                       |
// | Description : Streams a stored frame into the image processor one pixel at |
// |               a time and writes each adapted pixel into the result RAM,    |
// |               with independent timeouts on input_ready and output_valid.   |
// | Ports       : clk, rst_n          - clock, asynchronous active-low reset   |
// |               start, matrix_valid - frame request, accepted in IDLE only   |
// |                                     while the matrix is valid              |
// |               src_addr, src_rgb   - source RAM read port                   |
// |               input_rgb/valid     - pixel to processor, input_ready back   |
// |               output_rgb/valid    - adapted pixel from processor           |
// |               res_we/addr/data    - result RAM write port (1-cycle pulse)  |
// |               busy, done          - frame in progress / end-of-frame pulse |
// |               rdy_timeouts        - saturating input_ready timeout count   |
// |               out_timeouts        - saturating output_valid timeout count  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pixel_stream_sequencer
  import pixel_stream_sequencer_pkg::*;
#(
  parameter int      NUM_PIXELS = 24,
  parameter int      ADDR_W     = 5,
  parameter int      TIMEOUT    = 1000,
  parameter int      GAP_CYCLES = 5,
  parameter rgb888_t ERR_PIXEL  = C_ERR_PIXEL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              matrix_valid,
  output logic [ADDR_W-1:0] src_addr,
  input  rgb888_t           src_rgb,
  output rgb888_t           input_rgb,
  output logic              input_valid,
  input  logic              input_ready,
  input  rgb888_t           output_rgb,
  input  logic              output_valid,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output rgb888_t           res_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rdy_timeouts,
  output logic [7:0]        out_timeouts
);

  localparam logic [ADDR_W-1:0] C_LAST_INDEX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0] C_INDEX_ONE  = ADDR_W'(1);
  // The gap timer's flag is examined in the GAP cycle itself, so it must
  // fire one count early for the state to last exactly GAP_CYCLES cycles.
  localparam int                C_GAP_TERM   = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  rgb888_t           input_rgb_q, input_rgb_d;
  logic              input_valid_q, input_valid_d;
  logic              res_we_q, res_we_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  rgb888_t           res_data_q, res_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        rdy_to_q, rdy_to_d;
  logic [7:0]        out_to_q, out_to_d;

  logic              to_clear, to_enable, to_reached;
  logic              gap_clear, gap_enable, gap_reached;

  // ---------------------------------------------------------------------------
  // Timers. One timeout timer serves both WAIT_RDY and WAIT_OUT; it is
  // restarted in the single-cycle states just before each of them. While
  // waiting for ready only the stalled cycles count.
  // ---------------------------------------------------------------------------
  assign to_clear   = (state_q != ST_WAIT_RDY) && (state_q != ST_WAIT_OUT);
  assign to_enable  = ((state_q == ST_WAIT_RDY) && !input_ready) ||
                      (state_q == ST_WAIT_OUT);
  assign gap_clear  = (state_q != ST_GAP);
  assign gap_enable = (state_q == ST_GAP);

  pixel_stream_sequencer_cycle_timer #(
    .TERMINAL (TIMEOUT)
  ) u_timeout_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (to_clear),
    .enable  (to_enable),
    .reached (to_reached)
  );

  pixel_stream_sequencer_cycle_timer #(
    .TERMINAL (C_GAP_TERM)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (gap_clear),
    .enable  (gap_enable),
    .reached (gap_reached)
  );

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic. Pulsed outputs default low and
  // are raised on the transition into the cycle in which they are visible.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    input_rgb_d   = input_rgb_q;
    input_valid_d = 1'b0;
    res_we_d      = 1'b0;
    res_addr_d    = res_addr_q;
    res_data_d    = res_data_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    rdy_to_d      = rdy_to_q;
    out_to_d      = out_to_q;

    case (state_q)
      ST_IDLE: begin
        if (start && matrix_valid) begin
          state_d  = ST_FETCH;
          index_d  = '0;
          rdy_to_d = 8'd0;
          out_to_d = 8'd0;
          busy_d   = 1'b1;
        end
      end

      ST_FETCH: begin
        // src_addr has shown the current index throughout this cycle.
        input_rgb_d = src_rgb;
        state_d     = ST_WAIT_RDY;
      end

      ST_WAIT_RDY: begin
        if (input_ready) begin
          state_d       = ST_SEND;
          input_valid_d = 1'b1;
        end else if (to_reached) begin
          // A stalled processor still gets the pixel; the event is counted.
          rdy_to_d      = sat_inc8(rdy_to_q);
          state_d       = ST_SEND;
          input_valid_d = 1'b1;
        end
      end

      ST_SEND: begin
        state_d = ST_WAIT_OUT;
      end

      ST_WAIT_OUT: begin
        // A real result arriving on the terminal cycle beats the timeout.
        if (output_valid) begin
          res_we_d   = 1'b1;
          res_addr_d = index_q;
          res_data_d = output_rgb;
          state_d    = ST_GAP;
        end else if (to_reached) begin
          res_we_d   = 1'b1;
          res_addr_d = index_q;
          res_data_d = ERR_PIXEL;
          out_to_d   = sat_inc8(out_to_q);
          state_d    = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_reached) begin
          if (index_q == C_LAST_INDEX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + C_INDEX_ONE;
            state_d = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      index_q       <= '0;
      input_rgb_q   <= '0;
      input_valid_q <= 1'b0;
      res_we_q      <= 1'b0;
      res_addr_q    <= '0;
      res_data_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rdy_to_q      <= 8'd0;
      out_to_q      <= 8'd0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      input_rgb_q   <= input_rgb_d;
      input_valid_q <= input_valid_d;
      res_we_q      <= res_we_d;
      res_addr_q    <= res_addr_d;
      res_data_q    <= res_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rdy_to_q      <= rdy_to_d;
      out_to_q      <= out_to_d;
    end
  end

  assign src_addr     = index_q;
  assign input_rgb    = input_rgb_q;
  assign input_valid  = input_valid_q;
  assign res_we       = res_we_q;
  assign res_addr     = res_addr_q;
  assign res_data     = res_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign rdy_timeouts = rdy_to_q;
  assign out_timeouts = out_to_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pixel_stream_sequencer                                    |
// | Description : Self-checking bench: source RAM and image processor models,  |
// |               scoreboard of expected result-RAM writes.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pixel_stream_sequencer;
  import pixel_stream_sequencer_pkg::*;

  localparam int          NUM_PIXELS   = 24;
  localparam int          ADDR_W       = 5;
  localparam int          TIMEOUT      = 1000;
  localparam int          GAP_CYCLES   = 5;
  localparam logic [23:0] ERR_PIXEL    = 24'hFF0000;
  localparam int          PROC_DELAY   = 3;
  // SEND-to-SEND spacing: WAIT_OUT (PROC_DELAY) + GAP + FETCH + WAIT_RDY + SEND
  localparam int          SEND_SPACING = PROC_DELAY + GAP_CYCLES + 3;
  localparam int          FRAME_BUDGET = 5000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              matrix_valid = 1'b0;
  logic [ADDR_W-1:0] src_addr;
  logic [23:0]       src_rgb;
  logic [23:0]       input_rgb;
  logic              input_valid;
  logic              input_ready = 1'b1;
  logic [23:0]       output_rgb = 24'h0;
  logic              output_valid = 1'b0;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
  logic [23:0]       res_data;
  logic              busy;
  logic              done;
  logic [7:0]        rdy_timeouts;
  logic [7:0]        out_timeouts;

  pixel_stream_sequencer #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W),
    .TIMEOUT    (TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES),
    .ERR_PIXEL  (ERR_PIXEL)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .matrix_valid (matrix_valid),
    .src_addr     (src_addr),
    .src_rgb      (src_rgb),
    .input_rgb    (input_rgb),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_rgb   (output_rgb),
    .output_valid (output_valid),
    .res_we       (res_we),
    .res_addr     (res_addr),
    .res_data     (res_data),
    .busy         (busy),
    .done         (done),
    .rdy_timeouts (rdy_timeouts),
    .out_timeouts (out_timeouts)
  );

  always #5 clk = ~clk;

  // Source RAM: the registered address launched at one edge is sampled with
  // its data at the following edge.
  logic [23:0] src_mem [0:31];
  assign src_rgb = src_mem[src_addr];

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Per-frame configuration (written by the main sequence only)
  // ---------------------------------------------------------------------------
  int frame_id  = 0;
  int stall_pix = -1;          // pixel whose input_ready is held low
  bit stray_en  = 1'b0;        // pulse a junk output_valid during SEND
  int delay_cfg [0:NUM_PIXELS-1];  // processor latency per pixel, 0 = never

  // ---------------------------------------------------------------------------
  // Processor model + scoreboard (owns everything below)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [23:0]       data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int          seen_frame = 0;
  int          exp_idx    = 0;
  int          pend       = -1;
  logic [23:0] pend_val   = 24'h0;
  int          writes     = 0;
  int          done_cnt   = 0;
  int          cyc        = 0;
  int          last_send  = 0;
  int          spacing [0:NUM_PIXELS-1];
  logic [23:0] res_mem [0:31];

  initial begin
    forever begin
      @(negedge clk);
      if (frame_id != seen_frame) begin
        seen_frame = frame_id;
        exp_idx    = 0;
        pend       = -1;
        writes     = 0;
        done_cnt   = 0;
        sb_q.delete();
        for (int i = 0; i < NUM_PIXELS; i++) spacing[i] = 0;
        for (int i = 0; i < 32; i++) res_mem[i] = 24'h0;
      end
      cyc++;

      output_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          output_valid = 1'b1;
          output_rgb   = pend_val;
          pend         = -1;
        end
      end

      if (input_valid === 1'b1) begin
        check_value("send_idx_range", exp_idx < NUM_PIXELS, 1);
        if (exp_idx < NUM_PIXELS) begin
          check_value($sformatf("input_rgb_px%0d", exp_idx), input_rgb, src_mem[exp_idx]);
          sb_e.addr = ADDR_W'(exp_idx);
          sb_e.data = (delay_cfg[exp_idx] == 0) ? ERR_PIXEL : src_mem[exp_idx] + 24'd1;
          sb_q.push_back(sb_e);
          if (exp_idx > 0) spacing[exp_idx] = cyc - last_send;
          pend = (delay_cfg[exp_idx] > 0) ? delay_cfg[exp_idx] : -1;
        end
        last_send = cyc;
        pend_val  = input_rgb + 24'd1;
        if (stray_en) begin
          output_valid = 1'b1;
          output_rgb   = 24'h0BAD00;
        end
        exp_idx++;
      end

      if (res_we === 1'b1) begin
        check_value("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          sb_e = sb_q.pop_front();
          check_value("res_addr", res_addr, sb_e.addr);
          check_value($sformatf("res_data_px%0d", sb_e.addr), res_data, sb_e.data);
          res_mem[res_addr] = res_data;
          writes++;
        end
      end

      if (done === 1'b1) begin
        done_cnt++;
        check_value("busy_during_done", busy, 1);
      end

      input_ready = (exp_idx != stall_pix);
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence helpers (all act one time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_id++;
    wait_cyc(1);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_sent(input int n);
    int k = 0;
    while (exp_idx < n && k < FRAME_BUDGET) begin
      wait_cyc(1);
      k++;
    end
    check_value($sformatf("pixels_sent_%0d", n), exp_idx, n);
  endtask

  task automatic wait_done(input string tag, input int exp_rdy, input int exp_out);
    int k = 0;
    while (done_cnt == 0 && k < FRAME_BUDGET) begin
      wait_cyc(1);
      k++;
    end
    wait_cyc(3);
    check_value({tag, "_done_pulses"}, done_cnt, 1);
    check_value({tag, "_busy_after"}, busy, 0);
    check_value({tag, "_writes"}, writes, NUM_PIXELS);
    check_value({tag, "_rdy_timeouts"}, rdy_timeouts, exp_rdy);
    check_value({tag, "_out_timeouts"}, out_timeouts, exp_out);
  endtask

  initial begin
    src_mem[0]  = 24'h735244; src_mem[1]  = 24'hC29682; src_mem[2]  = 24'h627A9D;
    src_mem[3]  = 24'h576C43; src_mem[4]  = 24'h8580B1; src_mem[5]  = 24'h67BDAA;
    src_mem[6]  = 24'hD67E2C; src_mem[7]  = 24'h505BA6; src_mem[8]  = 24'hC15A63;
    src_mem[9]  = 24'h5E3C6C; src_mem[10] = 24'h9DBC40; src_mem[11] = 24'hE0A32E;
    src_mem[12] = 24'h383D96; src_mem[13] = 24'h469449; src_mem[14] = 24'hAF363C;
    src_mem[15] = 24'hE7C71F; src_mem[16] = 24'hBB5695; src_mem[17] = 24'h0885A1;
    src_mem[18] = 24'hF3F3F2; src_mem[19] = 24'hC8C8C8; src_mem[20] = 24'hA0A0A0;
    src_mem[21] = 24'h7A7A79; src_mem[22] = 24'h555555; src_mem[23] = 24'h343434;
    for (int i = NUM_PIXELS; i < 32; i++) src_mem[i] = 24'h0;
    for (int i = 0; i < NUM_PIXELS; i++) delay_cfg[i] = PROC_DELAY;

    // Reset state
    wait_cyc(3);
    check_value("rst_ctrl", {input_valid, res_we, busy, done, src_addr, res_addr}, 0);
    check_value("rst_data", {input_rgb, res_data}, 0);
    check_value("rst_counts", {rdy_timeouts, out_timeouts}, 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // start with no valid matrix is ignored
    start_frame();
    wait_cyc(6);
    check_value("no_matrix_busy", busy, 0);
    check_value("no_matrix_sent", exp_idx, 0);

    // Frame 1: ready always high, junk output_valid during SEND, start re-pulsed
    matrix_valid = 1'b1;
    stray_en     = 1'b1;
    start_frame();
    wait_cyc(1);
    check_value("f1_busy", busy, 1);
    wait_sent(4);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_done("f1", 0, 0);
    for (int i = 0; i < NUM_PIXELS; i++)
      check_value($sformatf("f1_res_mem%0d", i), res_mem[i], src_mem[i] + 24'd1);
    stray_en = 1'b0;

    // Frame 2: pixel 5 never sees input_ready; matrix_valid dropped mid-frame
    stall_pix = 5;
    start_frame();
    wait_cyc(3);
    matrix_valid = 1'b0;
    wait_done("f2", 1, 0);
    check_value("f2_spacing_px1", spacing[1], SEND_SPACING);
    check_value("f2_spacing_px5", spacing[5], SEND_SPACING + TIMEOUT);
    check_value("f2_spacing_px6", spacing[6], SEND_SPACING);
    stall_pix    = -1;
    matrix_valid = 1'b1;

    // Frame 3: pixel 7 never returns; pixel 12 returns on the terminal cycle
    delay_cfg[7]  = 0;
    delay_cfg[12] = TIMEOUT + 1;
    start_frame();
    wait_done("f3", 0, 1);
    check_value("f3_res_mem7", res_mem[7], ERR_PIXEL);
    check_value("f3_res_mem12", res_mem[12], src_mem[12] + 24'd1);
    delay_cfg[7]  = PROC_DELAY;
    delay_cfg[12] = PROC_DELAY;

    // Frame 4: reset while waiting for pixel 10's result
    delay_cfg[10] = 0;
    start_frame();
    wait_sent(11);
    wait_cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("abort_ctrl", {input_valid, res_we, busy, done, src_addr, res_addr}, 0);
    check_value("abort_data", {input_rgb, res_data}, 0);
    check_value("abort_counts", {rdy_timeouts, out_timeouts}, 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(3);
    check_value("abort_no_done", done_cnt, 0);
    check_value("abort_writes", writes, 10);
    check_value("abort_idle_busy", busy, 0);
    delay_cfg[10] = PROC_DELAY;

    // Frame 5: fresh start after the abort begins at address 0
    start_frame();
    wait_done("f5", 0, 0);
    check_value("f5_res_mem0", res_mem[0], src_mem[0] + 24'd1);
    check_value("f5_res_mem23", res_mem[23], src_mem[23] + 24'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pixel_stream_sequencer.md
Name: pixel_stream_sequencer

Overview:
- Hardware master that streams a stored frame into image_processor, one pixel at a time, and collects each adapted pixel into a result memory.
- Drives input_rgb/input_valid and honours input_ready on the processor input side; captures output_rgb/output_valid on the processor output side.
- Enforces per-pixel timeouts so a stalled processor cannot hang the frame.
- Sits between the frame source RAM, image_processor and the result RAM. Enabled once the Bradford compensation matrix is valid.

Parameters:
- NUM_PIXELS, 24, pixels per frame (6x4 colour checker by default); must be ≥1.
- ADDR_W, 5, source/result address width; must satisfy 2^ADDR_W ≥ NUM_PIXELS.
- TIMEOUT, 1000, maximum cycles to wait for ready, and separately for output_valid.
- GAP_CYCLES, 5, idle cycles inserted after each pixel completes.
- ERR_PIXEL, 24'hFF0000, value written to the result RAM when an output timeout occurs.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request, sampled in IDLE only
- matrix_valid  in  1  compensation matrix ready; start is ignored while low
- src_addr  out  ADDR_W  source RAM read address
- src_rgb  in  24  source RAM data, valid one cycle after src_addr
- input_rgb  out  24  pixel to image_processor
- input_valid  out  1  one-cycle pixel strobe
- input_ready  in  1  image_processor can accept a pixel
- output_rgb  in  24  adapted pixel from image_processor
- output_valid  in  1  adapted pixel strobe
- res_we  out  1  result RAM write enable (one-cycle pulse)
- res_addr  out  ADDR_W  result RAM write address
- res_data  out  24  result RAM write data
- busy  out  1  high from leaving IDLE until DONE completes
- done  out  1  one-cycle pulse at frame end
- rdy_timeouts  out  8  saturating count of input_ready timeouts this frame
- out_timeouts  out  8  saturating count of output_valid timeouts this frame

Behaviour:
- Reset values: all outputs 0; state IDLE; pixel index 0; timer 0. Reset asserted mid-frame aborts immediately with no write and no done pulse.
- FSM states and transitions:
  - IDLE: go to FETCH when start && matrix_valid. On entry to FETCH, clear pixel index and both timeout counters.
  - FETCH (1 cycle): src_addr = index. Go to WAIT_RDY; src_rgb is captured into input_rgb on the FETCH→WAIT_RDY edge.
  - WAIT_RDY: timer increments each cycle input_ready is low. If input_ready is high, go to SEND. If timer reaches TIMEOUT, increment rdy_timeouts and go to SEND anyway (the pixel is still sent).
  - SEND (1 cycle): input_valid = 1, input_rgb held. Clear timer. Go to WAIT_OUT. An output_valid arriving during SEND is ignored.
  - WAIT_OUT, case output_valid: res_we = 1, res_addr = index, res_data = output_rgb; go to GAP.
  - WAIT_OUT, case timer reaches TIMEOUT first: res_we = 1, res_data = ERR_PIXEL, increment out_timeouts; go to GAP.
  - WAIT_OUT, case output_valid in the same cycle the timer reaches TIMEOUT: output_valid wins; no timeout is counted.
  - GAP: wait exactly GAP_CYCLES cycles. Then, if index == NUM_PIXELS-1, go to DONE; otherwise increment index and go to FETCH. There is no wrap-around.
  - DONE (1 cycle): done = 1, busy still high. Go to IDLE.
- start while busy is ignored.
- matrix_valid falling mid-frame does not abort the frame.
- output_valid outside WAIT_OUT is ignored.
- Timeout counters saturate at 255.
- Timer width: $clog2(TIMEOUT+1).
- Per-pixel latency, minimum: 1 (FETCH) + 1 (WAIT_RDY) + 1 (SEND) + 1 (WAIT_OUT) + GAP_CYCLES.

Decomposition:
- Shared package: state enum (IDLE, FETCH, WAIT_RDY, SEND, WAIT_OUT, GAP, DONE), the ERR_PIXEL default, and the RGB888 pixel typedef.
- One sub-module: cycle_timer (clear, enable, terminal-count compare, registered reached flag), reused for both the TIMEOUT and the GAP counts.

Test Plan:
- input_ready tied high; processor model returns input+1 after 3 cycles; 24 checker pixels (0x735244 …).
  - Result RAM holds 0x735245 … at addresses 0-23.
  - Exactly one done pulse; both timeout counts 0.
- input_ready held low for the entire pixel 5 → input_valid still pulses after 1000 wait cycles; rdy_timeouts = 1; remaining pixels unaffected.
- Processor never asserts output_valid for pixel 7 → res_data = 0xFF0000 at address 7; out_timeouts = 1; frame completes.
- output_valid asserted in the exact cycle the timer hits TIMEOUT → real pixel is written; out_timeouts = 0.
- start pulsed with matrix_valid = 0 → stays IDLE, busy = 0. start re-pulsed while busy → no restart; index continues.
- rst_n asserted during WAIT_OUT of pixel 10 → all outputs 0 asynchronously, no done pulse. A new start after release processes from address 0.
